connect4_win_checker: RTL

//   Sequential win/draw evaluator for the Connect4 game. On a start pulse from the game FSM it

---
 rtl/connect4_win_checker.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/connect4_win_checker.sv
// rtl/connect4_win_checker.sv - sequential Connect4 win/draw evaluator, one (cell, direction) line per clock
module connect4_win_checker #(
    parameter int COLS    = 7,
    parameter int ROWS    = 6,
    parameter int WIN_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [2*COLS*ROWS-1:0] board_state,
    output logic                   busy,
    output logic                   done,
    output logic                   theres_a_winner,
    output logic [1:0]             winner_id,
    output logic [2*COLS*ROWS-1:0] winner_play,
    output logic                   draw
);

    localparam int CELLS = COLS * ROWS;
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t             state;
    logic [2*CELLS-1:0] snap;
    logic [CELLS-1:0]   acc_mask;
    logic [1:0]         acc_id;
    logic               full_q;
    logic [ROW_W-1:0]   row_q;
    logic [COL_W-1:0]   col_q;
    logic [1:0]         dir_q;

    int                 dr, dc, r, c, k, base;
    logic [1:0]         line_v;
    logic               line_ok;
    logic [CELLS-1:0]   line_mask;
    logic [CELLS-1:0]   acc_mask_n;
    logic [1:0]         acc_id_n;
    logic               full_n;
    logic               last_pair;

    always_comb begin
        dr = 0;
        dc = 1;
        case (dir_q)
            2'd0:    begin dr = 0; dc = 1;  end
            2'd1:    begin dr = 1; dc = 0;  end
            2'd2:    begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase

        base      = int'(row_q) * COLS + int'(col_q);
        line_v    = snap[2*base +: 2];
        line_ok   = (line_v == 2'b01) || (line_v == 2'b10);
        line_mask = '0;
        r         = 0;
        c         = 0;
        k         = 0;
        // Signed coordinates so a step past column 0 is rejected instead of wrapping.
        for (int i = 0; i < WIN_LEN; i++) begin
            r = int'(row_q) + i * dr;
            c = int'(col_q) + i * dc;
            if (r < 0 || r >= ROWS || c < 0 || c >= COLS) begin
                line_ok = 1'b0;
            end else begin
                k = r * COLS + c;
                if (snap[2*k +: 2] != line_v)
                    line_ok = 1'b0;
                line_mask[k] = 1'b1;
            end
        end

        acc_id_n   = acc_id;
        acc_mask_n = acc_mask;
        if (line_ok) begin
            if (acc_id == 2'b00) begin
                acc_id_n   = line_v;
                acc_mask_n = acc_mask | line_mask;
            end else if (acc_id == line_v) begin
                acc_mask_n = acc_mask | line_mask;
            end
        end

        full_n = full_q;
        if (dir_q == 2'd0 && (line_v == 2'b00 || line_v == 2'b11))
            full_n = 1'b0;

        last_pair = (row_q == ROW_LAST) && (col_q == COL_LAST) && (dir_q == 2'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            theres_a_winner <= 1'b0;
            winner_id       <= 2'b00;
            winner_play     <= '0;
            draw            <= 1'b0;
            snap            <= '0;
            acc_mask        <= '0;
            acc_id          <= 2'b00;
            full_q          <= 1'b1;
            row_q           <= '0;
            col_q           <= '0;
            dir_q           <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        snap     <= board_state;
                        acc_mask <= '0;
                        acc_id   <= 2'b00;
                        full_q   <= 1'b1;
                        row_q    <= '0;
                        col_q    <= '0;
                        dir_q    <= 2'd0;
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    acc_mask <= acc_mask_n;
                    acc_id   <= acc_id_n;
                    full_q   <= full_n;
                    if (dir_q == 2'd3) begin
                        dir_q <= 2'd0;
                        if (col_q == COL_LAST) begin
                            col_q <= '0;
                            row_q <= row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end else begin
                        dir_q <= dir_q + 1'b1;
                    end
                    // Results come from the next-state accumulators so they appear with done.
                    if (last_pair) begin
                        state           <= DONE;
                        busy            <= 1'b0;
                        done            <= 1'b1;
                        winner_play     <= {{CELLS{1'b0}}, acc_mask_n};
                        winner_id       <= acc_id_n;
                        theres_a_winner <= (acc_id_n != 2'b00);
                        draw            <= full_n & (acc_id_n == 2'b00);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
